seq_div7x3: RTL and testbench

SEQ_DIV7X3 -- requirements
Module: seq_div7x3

---
 rtl/seq_div_pkg.sv | 19 +
 rtl/seq_div7x3_div_step.sv | 22 ++
 rtl/seq_div7x3.sv | 172 +++++++++++++++++
 tb/tb_seq_div7x3.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared widths, step count and FSM state type for the 7-by-3 bit sequential divider.
// Used by seq_div7x3 and div_step; see seq_div7x3.sv for the SEQ_DIV_ZERO_CHECK_EN option.
package seq_div_pkg;

    localparam int DVD_W = 7;
    localparam int DVS_W = 3;
    localparam int STEPS = 7;
    localparam int CNT_W = 3;

    localparam logic [CNT_W-1:0] LAST_STEP  = CNT_W'(STEPS - 1);
    localparam logic [DVD_W-1:0] Q_ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div7x3_div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
module div_step
    import seq_div_pkg::*;
(
    input  logic [DVS_W-1:0] rem_i,
    input  logic             bit_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [DVS_W-1:0] rem_o,
    output logic             q_bit_o
);

    logic [DVS_W:0] trial;

    // The subtraction result always fits in DVS_W bits, so the low bits alone suffice.
    always_comb begin
        trial   = {rem_i, bit_i};
        q_bit_o = (trial >= {1'b0, divisor_i});
        rem_o   = q_bit_o ? (trial[DVS_W-1:0] - divisor_i) : trial[DVS_W-1:0];
    end

endmodule

// File: rtl/seq_div7x3.sv
// Sequential unsigned divider, 7-bit dividend by 3-bit divisor, one quotient bit per cycle.
// Optional macro SEQ_DIV_ZERO_CHECK_EN: divide-by-zero short-cuts straight to DONE with err=1.
module seq_div7x3
    import seq_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] q,
    output logic [DVS_W-1:0] r,
    output logic             err,
    output logic [1:0]       dbg_state
);

    state_t           state_q, state_d;
    logic [DVD_W-1:0] work_q, work_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DVD_W-1:0] q_q, q_d;
    logic [DVS_W-1:0] r_q, r_d;

    logic             accept;
    logic             load;
    logic             last_step;
    logic [DVS_W-1:0] step_rem;
    logic             step_qbit;

    div_step u_step (
        .rem_i     (rem_q),
        .bit_i     (work_q[DVD_W-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_step = (cnt_q == LAST_STEP);

`ifdef SEQ_DIV_ZERO_CHECK_EN
    logic zero_start;
    logic zero_load;
    logic err_q, err_d;

    assign zero_start = (divisor == '0);
    assign zero_load  = accept && zero_start;
    assign load       = accept && !zero_start;
`else
    assign load = accept;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    state_d = RUN;
`ifdef SEQ_DIV_ZERO_CHECK_EN
                end else if (zero_load) begin
                    state_d = DONE;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic, decoded from the state register only
    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        dbg_state = state_q;
    end

    // Datapath next values: operands shift left, quotient bits enter at the LSB,
    // so after the final step work holds the quotient.
    always_comb begin
        work_d = work_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        q_d    = q_q;
        r_d    = r_q;
        if (load) begin
            work_d = dividend;
            dvs_d  = divisor;
            rem_d  = '0;
            cnt_d  = '0;
        end else if (state_q == RUN) begin
            work_d = {work_q[DVD_W-2:0], step_qbit};
            rem_d  = step_rem;
            cnt_d  = last_step ? '0 : cnt_q + 1'b1;
            if (last_step) begin
                q_d = {work_q[DVD_W-2:0], step_qbit};
                r_d = step_rem;
            end
        end
`ifdef SEQ_DIV_ZERO_CHECK_EN
        if (zero_load) begin
            q_d = Q_ALL_ONES;
            r_d = dividend[DVS_W-1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_q <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
        end else begin
            work_q <= work_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            r_q    <= r_d;
        end
    end

`ifdef SEQ_DIV_ZERO_CHECK_EN
    // err is set by a zero-divisor start and cleared by any normal start.
    always_comb begin
        err_d = err_q;
        if (zero_load) begin
            err_d = 1'b1;
        end else if (load) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign q = q_q;
    assign r = r_q;

endmodule

// File: tb/tb_seq_div7x3.sv
// Self-checking bench for seq_div7x3: vector table, corner-case sequences and a full sweep.
module tb_seq_div7x3;

    localparam int W = 11;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] dividend;
    logic [2:0] divisor;
    logic       busy;
    logic       done;
    logic [6:0] q;
    logic [2:0] r;
    logic       err;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    seq_div7x3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Scoreboard: {err, q, r} pushed at start, popped when done is seen.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sb_exp;
    int           n_vec  = 0;
    int           n_fail = 0;

    typedef struct {
        logic [6:0] dvd;
        logic [2:0] dvs;
        logic [6:0] eq;
        logic [2:0] er;
        logic       ee;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [6:0] a, input logic [2:0] b);
        logic [6:0] qq;
        logic [6:0] rr;
        if (b == 3'd0) begin
            return {ZC, 7'h7F, a[2:0]};
        end
        qq = a / {4'b0, b};
        rr = a % {4'b0, b};
        return {1'b0, qq, rr[2:0]};
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got q=%0d r=%0d err=%0d, expected no done pulse", q, r, err);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({err, q, r} !== sb_exp) begin
                    n_fail++;
                    $display("FAIL result: got q=%0d r=%0d err=%0d, expected q=%0d r=%0d err=%0d",
                             q, r, err, sb_exp[9:3], sb_exp[2:0], sb_exp[10]);
                end
            end
        end
    end

    // Drives one division; chain=1 issues start in the current (done) cycle.
    // While the division runs, operands are scrambled and stray starts injected.
    task automatic do_div(input logic [6:0] a, input logic [2:0] b, input logic [W-1:0] exp_v,
                          input bit chain, input int pulse_at,
                          input logic [6:0] pa, input logic [2:0] pb);
        int lat;
        int nbusy;
        if (!chain) @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back(exp_v);
        lat   = 0;
        nbusy = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
            dividend = 7'($urandom_range(0, 127));
            divisor  = 3'($urandom_range(0, 7));
            start    = (k <= 6) && ($urandom_range(0, 3) == 0);
            if (k == pulse_at) begin
                start    = 1'b1;
                dividend = pa;
                divisor  = pb;
            end
        end
        start = 1'b0;
        check("done_latency", lat, (ZC && b == 3'd0) ? 1 : 8);
        check("busy_cycles", nbusy, (ZC && b == 3'd0) ? 0 : 7);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{7'd100, 3'd5, 7'd20,  3'd0, 1'b0};
        vecs[1]  = '{7'd127, 3'd7, 7'd18,  3'd1, 1'b0};
        vecs[2]  = '{7'd5,   3'd6, 7'd0,   3'd5, 1'b0};
        vecs[3]  = '{7'd83,  3'd3, 7'd27,  3'd2, 1'b0};
        vecs[4]  = '{7'd10,  3'd2, 7'd5,   3'd0, 1'b0};
        vecs[5]  = '{7'd83,  3'd0, 7'd127, 3'd3, ZC};
        vecs[6]  = '{7'd0,   3'd1, 7'd0,   3'd0, 1'b0};
        vecs[7]  = '{7'd127, 3'd1, 7'd127, 3'd0, 1'b0};
        vecs[8]  = '{7'd1,   3'd7, 7'd0,   3'd1, 1'b0};
        vecs[9]  = '{7'd64,  3'd3, 7'd21,  3'd1, 1'b0};
        vecs[10] = '{7'd126, 3'd6, 7'd21,  3'd0, 1'b0};
        vecs[11] = '{7'd0,   3'd0, 7'd127, 3'd0, ZC};

        // Reset with start held high: start must be ignored.
        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 7'd83;
        divisor  = 3'd3;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_q", q, 0);
        check("reset_r", r, 0);
        check("reset_err", err, 0);
        check("reset_state", dbg_state, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset_busy", busy, 0);

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            do_div(vecs[i].dvd, vecs[i].dvs, {vecs[i].ee, vecs[i].eq, vecs[i].er}, 1'b0, 0, 7'd0, 3'd0);
        end

        // Back-to-back: start issued in the DONE cycle.
        do_div(7'd127, 3'd7, {1'b0, 7'd18, 3'd1}, 1'b0, 0, 7'd0, 3'd0);
        do_div(7'd5, 3'd6, {1'b0, 7'd0, 3'd5}, 1'b1, 0, 7'd0, 3'd0);
        check("err_cleared", err, 0);

        // Zero divisor followed immediately by a normal start clears err.
        do_div(7'd83, 3'd0, {ZC, 7'd127, 3'd3}, 1'b0, 0, 7'd0, 3'd0);
        check("zero_div_err", err, 32'(ZC));
        do_div(7'd100, 3'd5, {1'b0, 7'd20, 3'd0}, 1'b1, 0, 7'd0, 3'd0);

        // Re-pulsed start while busy is ignored.
        do_div(7'd83, 3'd3, {1'b0, 7'd27, 3'd2}, 1'b0, 3, 7'd10, 3'd2);

        // Reset in the middle of a run abandons it.
        do_div(7'd127, 3'd7, {1'b0, 7'd18, 3'd1}, 1'b0, 0, 7'd0, 3'd0);
        @(negedge clk);
        dividend = 7'd100;
        divisor  = 3'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_done", done, 0);
        check("midrun_reset_q", q, 0);
        check("midrun_reset_r", r, 0);
        check("midrun_reset_err", err, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("no_done_after_reset", done, 0);
        end
        do_div(7'd127, 3'd7, {1'b0, 7'd18, 3'd1}, 1'b0, 0, 7'd0, 3'd0);

        // Exhaustive sweep over nonzero divisors, alternating idle gaps and back-to-back.
        for (int a = 0; a < 128; a++) begin
            for (int b = 1; b < 8; b++) begin
                do_div(7'(a), 3'(b), model(7'(a), 3'(b)), bit'(b[0]), 0, 7'd0, 3'd0);
            end
        end

        // A few random zero-divisor operations.
        for (int i = 0; i < 4; i++) begin
            dividend = 7'($urandom_range(0, 127));
            do_div(dividend, 3'd0, model(dividend, 3'd0), 1'b0, 0, 7'd0, 3'd0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
